ram_burst_master: RTL and testbench

- Initiator-side sequencer for the single-port `ram` (CLK/WE/ADDRESS/WD/RD).
- Accepts one burst command (start address, length, direction) over a valid/ready handshake.
- Write bursts: streams write words into sequential RAM addresses.
- Read bursts: streams RAM words out through a backpressured output register. Replaces hand-driven address/WE sequencing in the datapath.

---
 rtl/ram_burst_master.sv | 168 ++++++++++++++++
 tb/tb_ram_burst_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst sequencer for a single-port RAM with a combinational read port.
// It accepts one command (start address, length, direction) and then streams
// write words into consecutive addresses, or streams read words out through a
// backpressured output register. Addresses wrap modulo 2^ADDR_WIDTH.

// Protocol checker: a stalled read word must not change under the consumer.
module ram_burst_master_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rd_valid,
    input logic             rd_ready,
    input logic [WIDTH-1:0] rd_data
);
    rd_data_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_valid && !rd_ready) |=> $stable(rd_data))
        else $error("rd_data changed while the read word was stalled");
endmodule

module ram_burst_master #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [WIDTH-1:0]      WR_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [WIDTH-1:0]      RD_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic [WIDTH-1:0]      WD,
    input  logic [WIDTH-1:0]      RD
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                state_r,     state_s;
    logic [ADDR_WIDTH-1:0] addr_r,      addr_s;
    logic [LEN_WIDTH-1:0]  remaining_r, remaining_s;
    logic [WIDTH-1:0]      rd_data_r,   rd_data_s;
    logic                  rd_valid_r,  rd_valid_s;
    logic                  rd_beat_s;

    // A read beat may load the output register when it is empty or being consumed.
    assign rd_beat_s = !rd_valid_r || RD_READY;

    // State decodes; WE follows WR_VALID directly so a write lands on the same edge.
    assign CMD_READY = (state_r == ST_IDLE);
    assign WR_READY  = (state_r == ST_WRITE);
    assign WE        = (state_r == ST_WRITE) && WR_VALID;
    assign BUSY      = (state_r != ST_IDLE);
    assign DONE      = (state_r == ST_FINISH);
    assign ADDRESS   = addr_r;
    assign WD        = WR_DATA;
    assign RD_DATA   = rd_data_r;
    assign RD_VALID  = rd_valid_r;

    // Next-state, address/length bookkeeping and read-register loading.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        remaining_s = remaining_r;
        rd_data_s   = rd_data_r;
        rd_valid_s  = rd_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    addr_s      = CMD_ADDR;
                    remaining_s = CMD_LEN;
                    if (CMD_LEN == {LEN_WIDTH{1'b0}}) begin
                        state_s = ST_FINISH;
                    end else if (CMD_WRITE) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (WR_VALID) begin
                    addr_s      = addr_r + ADDR_WIDTH'(1);
                    remaining_s = remaining_r - LEN_WIDTH'(1);
                    if (remaining_r == LEN_WIDTH'(1)) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_beat_s) begin
                    rd_data_s   = RD;
                    rd_valid_s  = 1'b1;
                    addr_s      = addr_r + ADDR_WIDTH'(1);
                    remaining_s = remaining_r - LEN_WIDTH'(1);
                    if (remaining_r == LEN_WIDTH'(1)) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (rd_valid_r && RD_READY) begin
                    rd_valid_s = 1'b0;
                    state_s    = ST_FINISH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                rd_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst and drops a pending word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {LEN_WIDTH{1'b0}};
            rd_data_r   <= {WIDTH{1'b0}};
            rd_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            remaining_r <= remaining_s;
            rd_data_r   <= rd_data_s;
            rd_valid_r  <= rd_valid_s;
        end
    end

    ram_burst_master_chk #(.WIDTH(WIDTH)) u_chk (
        .clk      (CLK),
        .rst_n    (RST_N),
        .rd_valid (rd_valid_r),
        .rd_ready (RD_READY),
        .rd_data  (rd_data_r)
    );
endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural RAM attached.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_ram_burst_master;
    typedef struct {
        logic        cv;
        logic        cw;
        logic [9:0]  ca;
        logic [10:0] cl;
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic [5:0]  ef;  // {cmd_ready, wr_ready, we, busy, done, rd_valid}
        logic [9:0]  ea;
        logic        ec;  // compare rd_data
        logic [31:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, done, we;
    logic [9:0]  address;
    logic [31:0] wd, rd_word;
    logic        init_mem;
    logic [31:0] mem [0:1023];

    int vectors_applied = 0;
    int miscompares = 0;
    vec_t vecs [0:25];

    always #5 clk = ~clk;

    ram_burst_master dut (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
        .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data),
        .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data),
        .BUSY(busy), .DONE(done), .WE(we), .ADDRESS(address), .WD(wd), .RD(rd_word)
    );

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    // Behavioural single-port RAM: combinational read, write on rising edge.
    assign rd_word = mem[address];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
        end else if (we) begin
            mem[address] <= wd;
        end
    end

    function automatic vec_t mk(input logic cv, input logic cw, input logic [9:0] ca,
                                input logic [10:0] cl, input logic wv, input logic [31:0] wdat,
                                input logic rr, input logic [5:0] ef, input logic [9:0] ea,
                                input logic ec, input logic [31:0] ed);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wdat; v.rr = rr;
        v.ef = ef; v.ea = ea; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_len = v.cl;
        wr_valid = v.wv; wr_data = v.wd; rd_ready = v.rr;
    endtask

    task automatic check(input string name, input vec_t v);
        logic [5:0] got_f;
        got_f = {cmd_ready, wr_ready, we, busy, done, rd_valid};
        vectors_applied++;
        if (got_f !== v.ef || address !== v.ea || (v.ec && rd_data !== v.ed)) begin
            miscompares++;
            $display("FAIL %s: got flags=%b addr=%h rd_data=%h, expected flags=%b addr=%h rd_data=%h (checked=%0d)",
                     name, got_f, address, rd_data, v.ef, v.ea, v.ed, v.ec);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(name, v);
    endtask

    task automatic check_mem(input string name, input logic [9:0] a, input logic [31:0] exp);
        vectors_applied++;
        if (mem[a] !== exp) begin
            miscompares++;
            $display("FAIL %s: mem[%h] got %h, expected %h", name, a, mem[a], exp);
        end
    endtask

    initial begin
        // Main table: write burst, read-back, zero length, gapped write with ignored command.
        vecs[0]  = '{1'b1, 1'b1, 10'h010, 11'd4, 1'b0, 32'h0,    1'b0, 6'b100000, 10'h000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'h1001, 1'b0, 6'b011100, 10'h010, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'h1002, 1'b0, 6'b011100, 10'h011, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'h1003, 1'b0, 6'b011100, 10'h012, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'h1004, 1'b0, 6'b011100, 10'h013, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b000110, 10'h014, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b100000, 10'h014, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 10'h010, 11'd4, 1'b0, 32'h0,    1'b1, 6'b100000, 10'h014, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000100, 10'h010, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000101, 10'h011, 1'b1, 32'h1001};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000101, 10'h012, 1'b1, 32'h1002};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000101, 10'h013, 1'b1, 32'h1003};
        vecs[12] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000101, 10'h014, 1'b1, 32'h1004};
        vecs[13] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b000110, 10'h014, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b1, 6'b100000, 10'h014, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 10'h020, 11'd0, 1'b1, 32'hDEAD, 1'b0, 6'b100000, 10'h014, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hDEAD, 1'b0, 6'b000110, 10'h020, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b100000, 10'h020, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b1, 10'h030, 11'd3, 1'b0, 32'h0,    1'b0, 6'b100000, 10'h020, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hA1,   1'b0, 6'b011100, 10'h030, 1'b0, 32'h0};
        vecs[20] = '{1'b1, 1'b0, 10'h3FF, 11'd7, 1'b0, 32'h0,    1'b0, 6'b010100, 10'h031, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hA2,   1'b0, 6'b011100, 10'h031, 1'b0, 32'h0};
        vecs[22] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b010100, 10'h032, 1'b0, 32'h0};
        vecs[23] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hA3,   1'b0, 6'b011100, 10'h032, 1'b0, 32'h0};
        vecs[24] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b000110, 10'h033, 1'b0, 32'h0};
        vecs[25] = '{1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0,    1'b0, 6'b100000, 10'h033, 1'b0, 32'h0};

        // Reset state, with the RAM model preloaded during reset.
        rst_n = 1'b0;
        init_mem = 1'b1;
        drive(mk(1'b0, 1'b0, 10'h0, 11'd0, 1'b0, 32'h0, 1'b0, 6'b0, 10'h0, 1'b0, 32'h0));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset", mk(1'b0, 1'b0, 10'h0, 11'd0, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h000, 1'b1, 32'h0));
        init_mem = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) apply($sformatf("vec%0d", i), vecs[i]);
        check_mem("len0_nowrite", 10'h020, init_word(10'h020));

        // Read-back of the gapped write with 3 cycles of backpressure and a stalled drain.
        apply("bp_accept", mk(1'b1, 1'b0, 10'h030, 11'd3, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h033, 1'b0, 32'h0));
        apply("bp_first",  mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b0, 6'b000100, 10'h030, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++)
            apply($sformatf("bp_hold%0d", i),
                  mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b0, 6'b000101, 10'h031, 1'b1, 32'hA1));
        apply("bp_w1",     mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000101, 10'h031, 1'b1, 32'hA1));
        apply("bp_w2",     mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000101, 10'h032, 1'b1, 32'hA2));
        apply("bp_drhold", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b0, 6'b000101, 10'h033, 1'b1, 32'hA3));
        apply("bp_w3",     mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000101, 10'h033, 1'b1, 32'hA3));
        apply("bp_done",   mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000110, 10'h033, 1'b0, 32'h0));
        apply("bp_idle",   mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b100000, 10'h033, 1'b0, 32'h0));

        // Address wrap across the top of the RAM.
        apply("wrap_accept", mk(1'b1, 1'b1, 10'h3FE, 11'd4, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h033, 1'b0, 32'h0));
        apply("wrap_w0", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hB0, 1'b0, 6'b011100, 10'h3FE, 1'b0, 32'h0));
        apply("wrap_w1", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hB1, 1'b0, 6'b011100, 10'h3FF, 1'b0, 32'h0));
        apply("wrap_w2", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hB2, 1'b0, 6'b011100, 10'h000, 1'b0, 32'h0));
        apply("wrap_w3", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hB3, 1'b0, 6'b011100, 10'h001, 1'b0, 32'h0));
        apply("wrap_done", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b0, 6'b000110, 10'h002, 1'b0, 32'h0));
        apply("wrap_idle", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h002, 1'b0, 32'h0));
        check_mem("wrap_m0", 10'h3FE, 32'hB0);
        check_mem("wrap_m1", 10'h3FF, 32'hB1);
        check_mem("wrap_m2", 10'h000, 32'hB2);
        check_mem("wrap_m3", 10'h001, 32'hB3);

        // Reset asserted during the third of five writes.
        apply("rst_accept", mk(1'b1, 1'b1, 10'h040, 11'd5, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h002, 1'b0, 32'h0));
        apply("rst_w0", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hD0, 1'b0, 6'b011100, 10'h040, 1'b0, 32'h0));
        apply("rst_w1", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hD1, 1'b0, 6'b011100, 10'h041, 1'b0, 32'h0));
        apply("rst_w2", mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b1, 32'hD2, 1'b0, 6'b011100, 10'h042, 1'b0, 32'h0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", mk(1'b0, 1'b0, 10'h0, 11'd0, 1'b0, 32'h0, 1'b0, 6'b100000, 10'h000, 1'b1, 32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1'b0, 1'b0, 10'h0, 11'd0, 1'b0, 32'h0, 1'b1, 6'b0, 10'h0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        check("rst_release", mk(1'b0, 1'b0, 10'h0, 11'd0, 1'b0, 32'h0, 1'b1, 6'b100000, 10'h000, 1'b0, 32'h0));
        check_mem("rst_keep", 10'h041, 32'hD1);
        check_mem("rst_abort", 10'h042, init_word(10'h042));
        apply("rd1_accept", mk(1'b1, 1'b0, 10'h041, 11'd1, 1'b0, 32'h0, 1'b1, 6'b100000, 10'h000, 1'b0, 32'h0));
        apply("rd1_read",   mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000100, 10'h041, 1'b0, 32'h0));
        apply("rd1_drain",  mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000101, 10'h042, 1'b1, 32'hD1));
        apply("rd1_done",   mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b000110, 10'h042, 1'b0, 32'h0));
        apply("rd1_idle",   mk(1'b0, 1'b0, 10'h000, 11'd0, 1'b0, 32'h0, 1'b1, 6'b100000, 10'h042, 1'b0, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
